// File: rtl/camreg_arbiter_pkg.sv
// camreg_arbiter_pkg
//   Shared types and constants for the camera capture register bank:
//   register index enum, PEND/CTRL bit positions, port select, FSM states,
//   and a helper that zero-extends a 3-bit field to a 32-bit register word.
package camreg_arbiter_pkg;

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_PEND   = 2'd1,
        REG_IRQ_EN = 2'd2,
        REG_CTRL   = 2'd3
    } reg_idx_e;

    localparam int unsigned NUM_EVT   = 3;
    localparam int unsigned EVT_LINE  = 0;
    localparam int unsigned EVT_HISTO = 1;
    localparam int unsigned EVT_LOST  = 2;

    localparam int unsigned CTRL_CAPTURE_EN   = 0;
    localparam int unsigned CTRL_TEST_PATTERN = 1;

    typedef enum logic {
        NIOS = 1'b0,
        HPS  = 1'b1
    } port_sel_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StRecover = 2'd2
    } state_e;

    function automatic logic [31:0] word3(input logic [2:0] v);
        return {29'b0, v};
    endfunction

endpackage

// File: rtl/camreg_arbiter_if.sv
// camreg_arbiter_if
//   One register port of the camera capture register bank.
//   address      2   register index
//   bus_enable   1   request, held high until acknowledged
//   rw           1   1 = read, 0 = write
//   write_data  32   write data
//   read_data   32   read data, valid while acknowledge is high, 0 otherwise
//   acknowledge  1   one-cycle completion pulse
//   irq          1   per-port interrupt
interface camreg_arbiter_if;
    logic [1:0]  address;
    logic        bus_enable;
    logic        rw;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        acknowledge;
    logic        irq;

    modport master (
        output address, bus_enable, rw, write_data,
        input  read_data, acknowledge, irq
    );

    modport slave (
        input  address, bus_enable, rw, write_data,
        output read_data, acknowledge, irq
    );
endinterface

// File: rtl/camreg_arbiter_status_edge_detect.sv
// camreg_arbiter_status_edge_detect
//   Turns the linereader/cambus status levels into single-cycle event strobes.
//   clk, rst           clock, asynchronous active-low reset
//   which_line         line-buffer select (any change = line event)
//   which_histo        histogram-buffer select (any change = histo event)
//   vid_locked         cambus lock (1 -> 0 = lock-lost event)
//   line_evt, histo_evt, lost_evt   event strobes, valid for the coming edge
module camreg_arbiter_status_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic which_line,
    input  logic which_histo,
    input  logic vid_locked,
    output logic line_evt,
    output logic histo_evt,
    output logic lost_evt
);

    logic prev_line_q, prev_histo_q, prev_locked_q;
    logic armed_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_line_q   <= 1'b0;
            prev_histo_q  <= 1'b0;
            prev_locked_q <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            prev_line_q   <= which_line;
            prev_histo_q  <= which_histo;
            prev_locked_q <= vid_locked;
            armed_q       <= 1'b1;
        end
    end

    // prev flops hold reset values on the first cycle, so gate with armed_q
    // to avoid a spurious event from the reset-to-input difference.
    assign line_evt  = armed_q & (which_line ^ prev_line_q);
    assign histo_evt = armed_q & (which_histo ^ prev_histo_q);
    assign lost_evt  = armed_q & prev_locked_q & ~vid_locked;

endmodule

// File: rtl/camreg_arbiter.sv
// camreg_arbiter
//   Control/status register bank shared by the NIOS (nr) and HPS (hr) ports.
//   A round-robin FSM (IDLE -> ACCESS -> RECOVER) serves one access at a time.
//   clk, rst            clock, asynchronous active-low reset
//   status_which_line   linereader line-buffer select
//   status_which_histo  linereader histogram-buffer select
//   vid_locked          cambus lock indicator
//   ctrl_capture_en     CTRL[0]
//   ctrl_test_pattern   CTRL[1]
//   nr, hr              register ports (slave side)
module camreg_arbiter
    import camreg_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             status_which_line,
    input  logic             status_which_histo,
    input  logic             vid_locked,
    output logic             ctrl_capture_en,
    output logic             ctrl_test_pattern,
    camreg_arbiter_if.slave  nr,
    camreg_arbiter_if.slave  hr
);

    state_e          state_q, state_d;
    port_sel_e       last_grant_q, last_grant_d;
    port_sel_e       sel_q, sel_d;
    logic [31:0]     rd_q, rd_d;
    logic [1:0]      ctrl_q, ctrl_d;
    logic [2:0]      pend_n_q, pend_n_d, pend_h_q, pend_h_d;
    logic [2:0]      irq_en_n_q, irq_en_n_d, irq_en_h_q, irq_en_h_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;

    logic            line_evt, histo_evt, lost_evt;
    logic [2:0]      evt_vec;
    logic            grant;
    port_sel_e       grant_sel;
    reg_idx_e        g_addr;
    logic            g_rw;
    logic [2:0]      g_wdata;
    logic            wr_en;
    logic [2:0]      sel_pend, sel_en;
    logic [15:0]     cnt_ext;

    camreg_arbiter_status_edge_detect u_edge (
        .clk         (clk),
        .rst         (rst),
        .which_line  (status_which_line),
        .which_histo (status_which_histo),
        .vid_locked  (vid_locked),
        .line_evt    (line_evt),
        .histo_evt   (histo_evt),
        .lost_evt    (lost_evt)
    );

    always_comb begin
        evt_vec            = '0;
        evt_vec[EVT_LINE]  = line_evt;
        evt_vec[EVT_HISTO] = histo_evt;
        evt_vec[EVT_LOST]  = lost_evt;
    end

    assign cnt_ext = 16'(line_cnt_q);

    // Grant selection: on a tie, the port that did not win last time.
    always_comb begin
        grant = (state_q == StIdle) && (nr.bus_enable || hr.bus_enable);
        if (nr.bus_enable && hr.bus_enable) begin
            grant_sel = (last_grant_q == NIOS) ? HPS : NIOS;
        end else if (hr.bus_enable) begin
            grant_sel = HPS;
        end else begin
            grant_sel = NIOS;
        end
        g_addr   = reg_idx_e'((grant_sel == HPS) ? hr.address : nr.address);
        g_rw     = (grant_sel == HPS) ? hr.rw : nr.rw;
        g_wdata  = (grant_sel == HPS) ? hr.write_data[2:0] : nr.write_data[2:0];
        wr_en    = grant && !g_rw;
        sel_pend = (grant_sel == HPS) ? pend_h_q : pend_n_q;
        sel_en   = (grant_sel == HPS) ? irq_en_h_q : irq_en_n_q;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (grant) state_d = StAccess;
            StAccess:  state_d = StRecover;
            StRecover: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM: outputs. The non-selected port always sees ack=0, read_data=0.
    always_comb begin
        nr.acknowledge = 1'b0;
        hr.acknowledge = 1'b0;
        nr.read_data   = '0;
        hr.read_data   = '0;
        if (state_q == StAccess) begin
            if (sel_q == NIOS) begin
                nr.acknowledge = 1'b1;
                nr.read_data   = rd_q;
            end else begin
                hr.acknowledge = 1'b1;
                hr.read_data   = rd_q;
            end
        end
    end

    // Register bank next state. Read data is taken from the current (pre-write)
    // values; within PEND the W1C is applied first so a same-edge event wins.
    always_comb begin
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        rd_d         = rd_q;
        ctrl_d       = ctrl_q;
        pend_n_d     = pend_n_q;
        pend_h_d     = pend_h_q;
        irq_en_n_d   = irq_en_n_q;
        irq_en_h_d   = irq_en_h_q;
        line_cnt_d   = line_cnt_q + CNT_W'(line_evt);

        if (grant) begin
            last_grant_d = grant_sel;
            sel_d        = grant_sel;
            unique case (g_addr)
                REG_STATUS: rd_d = {cnt_ext, 13'b0, vid_locked, status_which_histo,
                                    status_which_line};
                REG_PEND:   rd_d = word3(sel_pend);
                REG_IRQ_EN: rd_d = word3(sel_en);
                REG_CTRL:   rd_d = {30'b0, ctrl_q};
                default:    rd_d = '0;
            endcase
        end

        if (wr_en) begin
            unique case (g_addr)
                REG_PEND: begin
                    if (grant_sel == NIOS) pend_n_d = pend_n_q & ~g_wdata;
                    else                   pend_h_d = pend_h_q & ~g_wdata;
                end
                REG_IRQ_EN: begin
                    if (grant_sel == NIOS) irq_en_n_d = g_wdata;
                    else                   irq_en_h_d = g_wdata;
                end
                REG_CTRL: ctrl_d = g_wdata[1:0];
                default: ;
            endcase
        end

        pend_n_d = pend_n_d | evt_vec;
        pend_h_d = pend_h_d | evt_vec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= HPS;
            sel_q        <= NIOS;
            rd_q         <= '0;
            ctrl_q       <= '0;
            pend_n_q     <= '0;
            pend_h_q     <= '0;
            irq_en_n_q   <= '0;
            irq_en_h_q   <= '0;
            line_cnt_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            rd_q         <= rd_d;
            ctrl_q       <= ctrl_d;
            pend_n_q     <= pend_n_d;
            pend_h_q     <= pend_h_d;
            irq_en_n_q   <= irq_en_n_d;
            irq_en_h_q   <= irq_en_h_d;
            line_cnt_q   <= line_cnt_d;
        end
    end

    assign ctrl_capture_en   = ctrl_q[CTRL_CAPTURE_EN];
    assign ctrl_test_pattern = ctrl_q[CTRL_TEST_PATTERN];

    // Registers only, so the irq lines cannot glitch.
    assign nr.irq = |(pend_n_q & irq_en_n_q);
    assign hr.irq = |(pend_h_q & irq_en_h_q);

endmodule

// File: tb/tb_camreg_arbiter.sv
module tb_camreg_arbiter;
    import camreg_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic which_line, which_histo, vid_locked;
    logic cap_en, test_pat;

    camreg_arbiter_if nr_if ();
    camreg_arbiter_if hr_if ();

    camreg_arbiter #(.CNT_W(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .status_which_line  (which_line),
        .status_which_histo (which_histo),
        .vid_locked         (vid_locked),
        .ctrl_capture_en    (cap_en),
        .ctrl_test_pattern  (test_pat),
        .nr                 (nr_if),
        .hr                 (hr_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int nr_ack_cyc = 0;
    int hr_ack_cyc = 0;
    int lat_n, lat_h;

    // Scoreboard entries: {is_read, expected read data}
    logic [32:0] nr_q[$];
    logic [32:0] hr_q[$];
    logic [32:0] nr_item, hr_item;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (nr_if.acknowledge === 1'b1) begin
            nr_ack_cyc = cyc;
            check_val("hr_quiet_during_nr_ack", {hr_if.read_data[31:1], hr_if.acknowledge}, 0);
            if (nr_q.size() == 0) begin
                check_val("nr_unexpected_ack", 1, 0);
            end else begin
                nr_item = nr_q.pop_front();
                if (nr_item[32]) check_val("nr_read_data", nr_if.read_data, nr_item[31:0]);
            end
        end
        if (hr_if.acknowledge === 1'b1) begin
            hr_ack_cyc = cyc;
            check_val("nr_quiet_during_hr_ack", {nr_if.read_data[31:1], nr_if.acknowledge}, 0);
            if (hr_q.size() == 0) begin
                check_val("hr_unexpected_ack", 1, 0);
            end else begin
                hr_item = hr_q.pop_front();
                if (hr_item[32]) check_val("hr_read_data", hr_if.read_data, hr_item[31:0]);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus access; optionally toggles which_line / drops vid_locked together
    // with raising the enable so an event lands on the grant edge.
    task automatic access(input bit hps, input bit rd, input logic [1:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp,
                          input bit tgl_line, input bit drop_lock, output int lat);
        int  n = 0;
        bit  seen = 1'b0;
        if (hps) begin
            hr_if.address = addr; hr_if.rw = rd; hr_if.write_data = wd;
            hr_if.bus_enable = 1'b1;
            hr_q.push_back({rd, exp});
        end else begin
            nr_if.address = addr; nr_if.rw = rd; nr_if.write_data = wd;
            nr_if.bus_enable = 1'b1;
            nr_q.push_back({rd, exp});
        end
        if (tgl_line) which_line = ~which_line;
        if (drop_lock) vid_locked = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            seen = hps ? hr_if.acknowledge : nr_if.acknowledge;
        end
        lat = n;
        if (hps) hr_if.bus_enable = 1'b0;
        else     nr_if.bus_enable = 1'b0;
        if (!seen) begin
            check_val(hps ? "hr_ack_timeout" : "nr_ack_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
            check_val("ack_single_cycle", hps ? hr_if.acknowledge : nr_if.acknowledge, 0);
        end
    endtask

    int lat;

    initial begin
        rst = 1'b0;
        which_line = 1'b1; which_histo = 1'b0; vid_locked = 1'b1;
        nr_if.bus_enable = 1'b0; nr_if.rw = 1'b1; nr_if.address = '0; nr_if.write_data = '0;
        hr_if.bus_enable = 1'b0; hr_if.rw = 1'b1; hr_if.address = '0; hr_if.write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ctrl_out", {30'b0, test_pat, cap_en}, 0);
        check_val("rst_ack_irq", {28'b0, nr_if.acknowledge, hr_if.acknowledge,
                                  nr_if.irq, hr_if.irq}, 0);
        rst = 1'b1;
        idle(2);

        // Reset with which_line=1: STATUS read, no pending bits
        access(0, 1, REG_STATUS, 0, 32'h0000_0005, 0, 0, lat);
        check_val("status_latency", lat, 1);
        access(0, 1, REG_PEND, 0, 32'h0, 0, 0, lat);
        access(1, 1, REG_PEND, 0, 32'h0, 0, 0, lat);
        access(1, 1, REG_CTRL, 0, 32'h0, 0, 0, lat);

        // Simultaneous CTRL writes: NIOS first (last_grant=HPS), HPS 3 cycles later
        idle(2);
        fork
            access(0, 0, REG_CTRL, 32'h1, 0, 0, 0, lat_n);
            access(1, 0, REG_CTRL, 32'h2, 0, 0, 0, lat_h);
        join
        check_val("nios_first_latency", lat_n, 1);
        check_val("hps_second_latency", lat_h, 4);
        check_val("grant_spacing", hr_ack_cyc - nr_ack_cyc, 3);
        check_val("ctrl_outputs", {30'b0, test_pat, cap_en}, 32'h2);
        access(1, 1, REG_CTRL, 0, 32'h2, 0, 0, lat);

        // IRQ enable, line event into both banks, W1C clears NIOS only
        access(0, 0, REG_IRQ_EN, 32'hFFFF_FFF9, 0, 0, 0, lat);
        access(0, 1, REG_IRQ_EN, 0, 32'h1, 0, 0, lat);
        access(1, 1, REG_IRQ_EN, 0, 32'h0, 0, 0, lat);
        which_line = 1'b0;
        idle(2);
        check_val("irq_after_line_evt", {30'b0, nr_if.irq, hr_if.irq}, 32'h2);
        access(0, 1, REG_PEND, 0, 32'h1, 0, 0, lat);
        access(1, 1, REG_PEND, 0, 32'h1, 0, 0, lat);
        access(0, 0, REG_PEND, 32'h1, 0, 0, 0, lat);
        check_val("nr_irq_after_w1c", nr_if.irq, 0);
        access(0, 1, REG_PEND, 0, 32'h0, 0, 0, lat);
        access(1, 1, REG_PEND, 0, 32'h1, 0, 0, lat);

        // W1C on the same edge as a line event: event wins
        idle(2);
        access(1, 0, REG_PEND, 32'h1, 0, 1, 0, lat);
        check_val("w1c_collision_latency", lat, 1);
        access(1, 1, REG_PEND, 0, 32'h1, 0, 0, lat);
        access(0, 1, REG_PEND, 0, 32'h1, 0, 0, lat);
        access(0, 1, REG_STATUS, 0, 32'h0002_0005, 0, 0, lat);

        // Lock lost during an HPS read
        idle(2);
        access(1, 1, REG_PEND, 0, 32'h1, 0, 1, lat);
        check_val("lock_drop_latency", lat, 1);
        access(1, 1, REG_PEND, 0, 32'h5, 0, 0, lat);
        access(0, 1, REG_PEND, 0, 32'h5, 0, 0, lat);
        check_val("irq_after_lost", {30'b0, nr_if.irq, hr_if.irq}, 32'h2);

        // Reset in the middle of ACCESS
        idle(2);
        hr_if.address = REG_STATUS; hr_if.rw = 1'b1; hr_if.bus_enable = 1'b1;
        @(posedge clk);
        #1;
        check_val("pre_reset_ack", hr_if.acknowledge, 1);
        rst = 1'b0;
        #1;
        check_val("reset_drops_ack", hr_if.acknowledge, 0);
        check_val("reset_read_data", hr_if.read_data, 0);
        check_val("reset_ctrl_irq", {29'b0, test_pat, cap_en, nr_if.irq}, 0);
        hr_if.bus_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        access(0, 1, REG_PEND, 0, 32'h0, 0, 0, lat);
        access(0, 1, REG_CTRL, 0, 32'h0, 0, 0, lat);

        // line_cnt wrap: 0xFFFF events, then one more
        for (int i = 0; i < 65535; i++) begin
            which_line = ~which_line;
            @(posedge clk);
            #1;
        end
        idle(1);
        access(0, 1, REG_STATUS, 0, 32'hFFFF_0000, 0, 0, lat);
        which_line = ~which_line;
        idle(2);
        access(0, 1, REG_STATUS, 0, 32'h0000_0001, 0, 0, lat);

        // Histogram event
        which_histo = 1'b1;
        idle(2);
        access(1, 1, REG_PEND, 0, 32'h3, 0, 0, lat);
        access(0, 1, REG_PEND, 0, 32'h3, 0, 0, lat);

        idle(2);
        check_val("nr_scoreboard_drained", nr_q.size(), 0);
        check_val("hr_scoreboard_drained", hr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
